// File: rtl/rdft_sample_history.sv
// rdft_sample_history: DEPTH-deep complex sample history returning x[n-DEPTH] per accepted x[n]
module rdft_sample_history #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inData,
  input  logic [WIDTH-1:0] j_inData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outData,
  output logic [WIDTH-1:0] j_outData,
  output logic             primed
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {FILL, RUN} state_t;
  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, fill_cnt_q, fill_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [WIDTH-1:0] ram_re [DEPTH];
  logic [WIDTH-1:0] ram_im [DEPTH];
  logic             accept;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign outData   = out_re_q;
  assign j_outData = out_im_q;
  assign primed    = state_q == RUN;
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (flush) begin
      state_d     = FILL;
      wr_ptr_d    = '0;
      fill_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_re_d    = '0;
      out_im_d    = '0;
    end else if (accept) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (state_q == FILL) begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        state_d    = (fill_cnt_q == AW'(DEPTH - 1)) ? RUN : FILL;
      end else begin
        // the slot about to be overwritten holds the oldest sample
        out_valid_d = 1'b1;
        out_re_d    = ram_re[wr_ptr_q];
        out_im_d    = ram_im[wr_ptr_q];
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      ram_re[wr_ptr_q] <= inData;
      ram_im[wr_ptr_q] <= j_inData;
    end
  end
endmodule

// File: tb/tb_rdft_sample_history.sv
// tb_rdft_sample_history: directed checks of the sample history on DEPTH=4 and DEPTH=5 instances
module tb_rdft_sample_history;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_re, in_im;
  logic        rdy4, ov4, pr4, rdy5, ov5, pr5;
  logic [31:0] o_re4, o_im4, o_re5, o_im5;
  int          vectors = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  rdft_sample_history #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
    .inData(in_re), .j_inData(in_im), .out_valid(ov4), .out_ready(out_ready),
    .outData(o_re4), .j_outData(o_im4), .primed(pr4)
  );
  rdft_sample_history #(.WIDTH(32), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy5),
    .inData(in_re), .j_inData(in_im), .out_valid(ov5), .out_ready(out_ready),
    .outData(o_re5), .j_outData(o_im5), .primed(pr5)
  );
  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic push(input logic [31:0] re, input logic [31:0] im);
    in_valid = 1'b1; in_re = re; in_im = im;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    #1;
    vectors++;
    if ({ov4, pr4, rdy4, o_re4, o_im4} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
      errors++; $display("FAIL reset4: got v=%b p=%b r=%b %h/%h want 0 0 1 0/0", ov4, pr4, rdy4, o_re4, o_im4);
    end
    vectors++;
    if ({ov5, pr5, rdy5, o_re5, o_im5} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
      errors++; $display("FAIL reset5: got v=%b p=%b r=%b %h/%h want 0 0 1 0/0", ov5, pr5, rdy5, o_re5, o_im5);
    end
    do_reset();
  endtask
  task automatic test_fill_stream();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      push(32'(k), 32'(-k));
      vectors++;
      if (pr4 !== (k >= 4)) begin
        errors++; $display("FAIL fill_primed k=%0d: got %b want %b", k, pr4, k >= 4);
      end
      vectors++;
      if (ov4 !== (k >= 5)) begin
        errors++; $display("FAIL fill_valid k=%0d: got %b want %b", k, ov4, k >= 5);
      end
      if (k >= 5) begin
        vectors++;
        if (o_re4 !== 32'(k - 4) || o_im4 !== 32'(4 - k)) begin
          errors++; $display("FAIL fill_data k=%0d: got %h/%h want %h/%h", k, o_re4, o_im4, 32'(k - 4), 32'(4 - k));
        end
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (ov4 !== 1'b0) begin
      errors++; $display("FAIL drain_valid: got %b want 0", ov4);
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      push(32'(k), 32'(-k));
      vectors++;
      if (ov5 !== (k >= 5)) begin
        errors++; $display("FAIL wrap_valid k=%0d: got %b want %b", k, ov5, k >= 5);
      end
      if (k >= 5) begin
        vectors++;
        if (o_re5 !== 32'(k - 5) || o_im5 !== 32'(5 - k)) begin
          errors++; $display("FAIL wrap_data k=%0d: got %h/%h want %h/%h", k, o_re5, o_im5, 32'(k - 5), 32'(5 - k));
        end
      end
    end
    in_valid = 1'b0;
  endtask
  task automatic test_back_pressure();
    do_reset();
    for (int k = 1; k <= 5; k++) push(32'(k), 32'(-k));
    out_ready = 1'b0;
    in_valid = 1'b1; in_re = 32'd6; in_im = 32'(-6);
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (rdy4 !== 1'b0 || ov4 !== 1'b1 || o_re4 !== 32'd1 || o_im4 !== 32'(-1)) begin
        errors++; $display("FAIL stall c=%0d: got r=%b v=%b %h/%h want 0 1 1/-1", c, rdy4, ov4, o_re4, o_im4);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (rdy4 !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b want 1", rdy4);
    end
    @(posedge clk); #1;
    vectors++;
    if (ov4 !== 1'b1 || o_re4 !== 32'd2 || o_im4 !== 32'(-2)) begin
      errors++; $display("FAIL resume1: got v=%b %h/%h want 1 2/-2", ov4, o_re4, o_im4);
    end
    push(32'd7, 32'(-7));
    vectors++;
    if (ov4 !== 1'b1 || o_re4 !== 32'd3 || o_im4 !== 32'(-3)) begin
      errors++; $display("FAIL resume2: got v=%b %h/%h want 1 3/-3", ov4, o_re4, o_im4);
    end
    in_valid = 1'b0;
  endtask
  task automatic test_flush();
    do_reset();
    for (int k = 1; k <= 6; k++) push(32'(k), 32'(-k));
    flush = 1'b1;
    push(32'd99, 32'(-99));
    flush = 1'b0;
    vectors++;
    if (ov4 !== 1'b0 || pr4 !== 1'b0 || o_re4 !== 32'd0 || o_im4 !== 32'd0) begin
      errors++; $display("FAIL flush: got v=%b p=%b %h/%h want 0 0 0/0", ov4, pr4, o_re4, o_im4);
    end
    for (int k = 11; k <= 14; k++) begin
      push(32'(k), 32'(-k));
      vectors++;
      if (ov4 !== 1'b0 || pr4 !== (k == 14)) begin
        errors++; $display("FAIL refill k=%0d: got v=%b p=%b want 0 %b", k, ov4, pr4, k == 14);
      end
    end
    push(32'd15, 32'(-15));
    vectors++;
    if (ov4 !== 1'b1 || o_re4 !== 32'd11 || o_im4 !== 32'(-11)) begin
      errors++; $display("FAIL post_flush: got v=%b %h/%h want 1 11/-11", ov4, o_re4, o_im4);
    end
    in_valid = 1'b0;
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int k = 1; k <= 5; k++) push(32'(k), 32'(-k));
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({ov4, pr4, rdy4, o_re4, o_im4} !== {1'b0, 1'b0, 1'b1, 64'd0}) begin
      errors++; $display("FAIL async_rst: got v=%b p=%b r=%b %h/%h want 0 0 1 0/0", ov4, pr4, rdy4, o_re4, o_im4);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      push(32'(k), 32'(-k));
      vectors++;
      if (ov4 !== (k == 5)) begin
        errors++; $display("FAIL rerun_valid k=%0d: got %b want %b", k, ov4, k == 5);
      end
    end
    vectors++;
    if (o_re4 !== 32'd1 || o_im4 !== 32'(-1)) begin
      errors++; $display("FAIL rerun_data: got %h/%h want 1/-1", o_re4, o_im4);
    end
    in_valid = 1'b0;
  endtask
  task automatic test_extremes();
    do_reset();
    push(32'h7FFF_FFFF, 32'h8000_0000);
    push(32'h8000_0000, 32'h7FFF_FFFF);
    push(32'd0, 32'd0);
    push(32'd0, 32'd0);
    push(32'd1, 32'd1);
    vectors++;
    if (ov4 !== 1'b1 || o_re4 !== 32'h7FFF_FFFF || o_im4 !== 32'h8000_0000) begin
      errors++; $display("FAIL extreme_a: got v=%b %h/%h want 1 7fffffff/80000000", ov4, o_re4, o_im4);
    end
    push(32'd2, 32'd2);
    vectors++;
    if (ov4 !== 1'b1 || o_re4 !== 32'h8000_0000 || o_im4 !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL extreme_b: got v=%b %h/%h want 1 80000000/7fffffff", ov4, o_re4, o_im4);
    end
    in_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_fill_stream();
    test_wrap();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
